bcd_down_timer: RTL and testbench



---
 rtl/bcd_down_timer.sv | 138 +++++++++++++
 tb/tb_bcd_down_timer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_down_timer.sv
// ---------------------------------------------------------------------------
// bcd_down_timer
//   Presettable multi-digit BCD countdown timer. It loads a BCD preset,
//   counts down one step per enabled clock while running, pulses TC for one
//   cycle on reaching terminal count, then stops in DONE.
//
//   Optional feature (define AUTO_RELOAD_EN): on terminal count the preset
//   held in the reload register is loaded back into Q. The timer stays in
//   RUN and TC still pulses. A zero reload value falls back to DONE.
//
// Parameters
//   DIGITS : number of BCD digits; Q and D are 4*DIGITS bits wide.
//
// Ports
//   CP    : clock, rising edge
//   CLR   : synchronous active-high clear (highest priority)
//   PE    : synchronous parallel load of sanitised D (aborts a countdown)
//   D     : BCD preset, digit 0 = D[3:0]; digits above 9 load as 9
//   START : begin countdown from IDLE when Q is non-zero
//   EN    : count enable while running; 0 holds Q
//   Q     : registered BCD count
//   BUSY  : high while in RUN
//   TC    : one-cycle terminal-count pulse
//   ZERO  : combinational Q == 0
// ---------------------------------------------------------------------------
module bcd_down_timer #(
    parameter int DIGITS = 4
) (
    input  logic                CP,
    input  logic                CLR,
    input  logic                PE,
    input  logic [4*DIGITS-1:0] D,
    input  logic                START,
    input  logic                EN,
    output logic [4*DIGITS-1:0] Q,
    output logic                BUSY,
    output logic                TC,
    output logic                ZERO
);

    localparam int W = 4 * DIGITS;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]   state;
    logic [W-1:0] d_clean;
    logic [W-1:0] q_dec;
    logic         q_is_one;

`ifdef AUTO_RELOAD_EN
    logic [W-1:0] reload;
`endif

    // Clamp any non-BCD preset digit to 9.
    always_comb begin
        d_clean = '0;
        for (int i = 0; i < DIGITS; i++) begin
            d_clean[4*i +: 4] = (D[4*i +: 4] > 4'd9) ? 4'd9 : D[4*i +: 4];
        end
    end

    // BCD decrement with a borrow ripple. The top digit's final borrow is
    // dropped: the count is never decremented from zero.
    always_comb begin
        logic borrow;
        borrow = 1'b1;
        q_dec  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (Q[4*i +: 4] == 4'd0) begin
                    q_dec[4*i +: 4] = 4'd9;
                end else begin
                    q_dec[4*i +: 4] = Q[4*i +: 4] - 4'd1;
                    borrow          = 1'b0;
                end
            end else begin
                q_dec[4*i +: 4] = Q[4*i +: 4];
            end
        end
    end

    assign q_is_one = (Q == W'(1));
    assign ZERO     = (Q == '0);
    assign BUSY     = (state == S_RUN);

    always_ff @(posedge CP) begin
        if (CLR) begin
            Q     <= '0;
            state <= S_IDLE;
            TC    <= 1'b0;
`ifdef AUTO_RELOAD_EN
            reload <= '0;
`endif
        end else if (PE) begin
            Q     <= d_clean;
            state <= S_IDLE;
            TC    <= 1'b0;
`ifdef AUTO_RELOAD_EN
            reload <= d_clean;
`endif
        end else begin
            TC <= 1'b0;
            case (state)
                S_IDLE: begin
                    // A zero count has nothing to run: stay idle, no TC.
                    if (START && !ZERO) state <= S_RUN;
                end
                S_RUN: begin
                    if (EN) begin
                        if (q_is_one) begin
                            TC <= 1'b1;
`ifdef AUTO_RELOAD_EN
                            if (reload != '0) begin
                                Q <= reload;
                            end else begin
                                Q     <= '0;
                                state <= S_DONE;
                            end
`else
                            Q     <= '0;
                            state <= S_DONE;
`endif
                        end else begin
                            Q <= q_dec;
                        end
                    end
                end
                S_DONE: begin
                    // Terminal state: only PE or CLR leave it.
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_down_timer.sv
// ---------------------------------------------------------------------------
// tb_bcd_down_timer
//   Directed self-checking bench for bcd_down_timer (DIGITS = 4). Inputs are
//   changed 1 time unit after a rising edge; outputs are checked at that
//   point, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_bcd_down_timer;

    logic        CP = 1'b0;
    logic        CLR = 1'b0;
    logic        PE = 1'b0;
    logic [15:0] D = '0;
    logic        START = 1'b0;
    logic        EN = 1'b0;
    logic [15:0] Q;
    logic        BUSY;
    logic        TC;
    logic        ZERO;

    int checks = 0;
    int fails  = 0;

    bcd_down_timer #(.DIGITS(4)) dut (
        .CP    (CP),
        .CLR   (CLR),
        .PE    (PE),
        .D     (D),
        .START (START),
        .EN    (EN),
        .Q     (Q),
        .BUSY  (BUSY),
        .TC    (TC),
        .ZERO  (ZERO)
    );

    always #5 CP = ~CP;

    task automatic tick();
        @(posedge CP);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Decimal to 4-digit BCD, used for hand-written expected sequences.
    function automatic logic [15:0] bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic load(input logic [15:0] val);
        PE = 1'b1; D = val;
        tick();
        PE = 1'b0;
    endtask

    initial begin
        // Reset state
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        tick();
        check("rst_q",    Q,            16'h0000);
        check("rst_busy", 16'(BUSY),    16'h0000);
        check("rst_tc",   16'(TC),      16'h0000);
        check("rst_zero", 16'(ZERO),    16'h0001);

        // START with Q == 0 in IDLE: stays idle, no TC
        START = 1'b1;
        tick();
        START = 1'b0;
        check("idle0_busy", 16'(BUSY), 16'h0000);
        check("idle0_tc",   16'(TC),   16'h0000);
        EN = 1'b1;
        tick();
        check("idle0_q", Q, 16'h0000);
        EN = 1'b0;

        // Sanitised loads
        load(16'h00A5);
        check("san_a5", Q, 16'h0095);
        check("san_a5_busy", 16'(BUSY), 16'h0000);
        load(16'hF0B7);
        check("san_f0b7", Q, 16'h9097);

        // Borrow across all digits: 1000 -> 0999
        load(16'h1000);
        START = 1'b1;
        tick();
        START = 1'b0;
        check("b1000_busy", 16'(BUSY), 16'h0001);
        check("b1000_hold", Q, 16'h1000);
        EN = 1'b1;
        tick();
        EN = 1'b0;
        check("b1000_q", Q, 16'h0999);
        check("b1000_zero", 16'(ZERO), 16'h0000);

        // EN hold then PE abort
        load(16'h0050);
        START = 1'b1;
        tick();
        START = 1'b0;
        EN = 1'b1;
        tick(); tick(); tick();
        check("hold_q47", Q, 16'h0047);
        EN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_q", Q, 16'h0047);
            check("hold_busy", 16'(BUSY), 16'h0001);
        end
        load(16'h0020);
        check("abort_q",    Q,         16'h0020);
        check("abort_busy", 16'(BUSY), 16'h0000);
        check("abort_tc",   16'(TC),   16'h0000);

        // CLR mid-run
        load(16'h0035);
        START = 1'b1;
        tick();
        START = 1'b0;
        EN = 1'b1;
        tick(); tick();
        check("clr_pre_q", Q, 16'h0033);
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        EN = 1'b0;
        check("clr_q",    Q,         16'h0000);
        check("clr_busy", 16'(BUSY), 16'h0000);
        check("clr_tc",   16'(TC),   16'h0000);

`ifdef AUTO_RELOAD_EN
        // Auto reload: 3,2,1 repeating; TC on each reload to 3
        load(16'h0003);
        START = 1'b1;
        tick();
        START = 1'b0;
        EN = 1'b1;
        begin
            int seq [9] = '{2, 1, 3, 2, 1, 3, 2, 1, 3};
            for (int i = 0; i < 9; i++) begin
                tick();
                check("ar_q",    Q,                    bcd(seq[i]));
                check("ar_tc",   16'(TC),              16'(seq[i] == 3));
                check("ar_busy", 16'(BUSY),            16'h0001);
            end
        end
        EN = 1'b0;
`else
        // Full countdown from 0012 to terminal count
        load(16'h0012);
        START = 1'b1;
        tick();
        START = 1'b0;
        check("run_q12", Q, 16'h0012);
        EN = 1'b1;
        for (int v = 11; v >= 0; v--) begin
            tick();
            check("run_q",    Q,         bcd(v));
            check("run_tc",   16'(TC),   16'(v == 0));
            check("run_busy", 16'(BUSY), 16'(v != 0));
        end
        tick();
        check("done_q",    Q,         16'h0000);
        check("done_tc",   16'(TC),   16'h0000);
        check("done_busy", 16'(BUSY), 16'h0000);
        check("done_zero", 16'(ZERO), 16'h0001);
        // START ignored in DONE
        START = 1'b1;
        tick();
        START = 1'b0;
        tick();
        check("done_start_busy", 16'(BUSY), 16'h0000);
        check("done_start_q",    Q,         16'h0000);
        EN = 1'b0;
        // PE leaves DONE
        load(16'h0002);
        check("done_pe_q", Q, 16'h0002);
`endif

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
